change_logger: RTL

CHANGE_LOGGER -- requirements
Module: change_logger

---
 rtl/change_logger.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/change_logger.sv
// change_logger: watches a single result bit and logs every change of it as
// a {timestamp, new value} record in a small FIFO for a downstream consumer.
// Records are offered on a valid/ready interface and are presented oldest
// first. A record that arrives while the FIFO is full and nothing is being
// consumed is dropped, and the sticky ovf flag is set.
// Optional feature macro: CHANGE_LOGGER_OVF_CNT_EN adds an 8-bit saturating
// count of dropped records on port ovf_cnt.
module change_logger #(
  parameter int TS_W  = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TS_W-1:0]          out_ts,
  output logic                     out_val,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf
`ifdef CHANGE_LOGGER_OVF_CNT_EN
  ,
  output logic [7:0]               ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Architectural state
  logic              z_q_r;
  logic [TS_W-1:0]   ts_r;
  logic [TS_W-1:0]   mem_ts_r  [DEPTH];
  logic              mem_val_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r;

  // Registered copies of the head record and the valid flag, so that every
  // output comes straight from a flop.
  logic              valid_r;
  logic [TS_W-1:0]   head_ts_r;
  logic              head_val_r;

  // Next-state / control signals
  logic              event_s;
  logic              full_s;
  logic              pop_s;
  logic              push_s;
  logic              drop_s;
  logic [AW-1:0]     rd_ptr_nxt_s;
  logic [AW-1:0]     wr_ptr_nxt_s;
  logic [CW-1:0]     count_nxt_s;
  logic [TS_W-1:0]   head_ts_nxt_s;
  logic              head_val_nxt_s;

  // Change detection and push/pop/drop decisions for this cycle.
  always_comb begin
    event_s = (z != z_q_r);
    full_s  = (count_r == CW'(DEPTH));
    pop_s   = valid_r & out_ready;
    // A full FIFO still accepts a record when the head leaves in the same cycle.
    push_s  = event_s & (~full_s | pop_s);
    drop_s  = event_s & full_s & ~pop_s;
  end

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + AW'(1'b1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1'b1);
      2'b01:   count_nxt_s = count_r - CW'(1'b1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Head record after this edge: the newly pushed record becomes the head
  // when it lands exactly at the next read position (FIFO empty after any
  // pop), otherwise the head is read from storage at the next read pointer.
  always_comb begin
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_ts_nxt_s  = ts_r;
      head_val_nxt_s = z;
    end else begin
      head_ts_nxt_s  = mem_ts_r[rd_ptr_nxt_s];
      head_val_nxt_s = mem_val_r[rd_ptr_nxt_s];
    end
  end

  // Control state: sampled z, timestamp counter, pointers, occupancy, flags and head registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      z_q_r      <= 1'b0;
      ts_r       <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      ovf_r      <= 1'b0;
      valid_r    <= 1'b0;
      head_ts_r  <= '0;
      head_val_r <= 1'b0;
    end else begin
      z_q_r      <= z;
      ts_r       <= ts_r + TS_W'(1'b1);
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      valid_r    <= (count_nxt_s != '0);
      head_ts_r  <= head_ts_nxt_s;
      head_val_r <= head_val_nxt_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // Record storage; contents need no reset because occupancy gates their use.
  always_ff @(posedge clk) begin
    if (push_s && !rst) begin
      mem_ts_r[wr_ptr_r]  <= ts_r;
      mem_val_r[wr_ptr_r] <= z;
    end
  end

`ifdef CHANGE_LOGGER_OVF_CNT_EN
  logic [7:0] ovf_cnt_r;

  // Saturating count of dropped records.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_r <= 8'd0;
    end else if (drop_s && (ovf_cnt_r != 8'hFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_r;
`endif

  assign out_valid = valid_r;
  assign out_ts    = head_ts_r;
  assign out_val   = head_val_r;
  assign count     = count_r;
  assign ovf       = ovf_r;

endmodule
